// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared types and constants for the SHA-256 message padder.
//   state_e      : padder FSM states
//   ADDR_START   : register address of the hash core's start register
//   START_FIRST  : start code for a message's first block (load initial hash value)
//   START_CHAIN  : start code for every later block (chain from previous digest)
//   PAD_BYTE     : the single 1-bit marker byte that follows the message
package sha256_pkg;

   typedef enum logic [2:0] {FILL, PAD, EMIT, WAIT, ZERO} state_e;

   localparam logic [4:0]  ADDR_START  = 5'd16;
   localparam logic [31:0] START_FIRST = 32'hFFFF_FFFF;
   localparam logic [31:0] START_CHAIN = 32'hFFFF_FFFE;
   localparam logic [7:0]  PAD_BYTE    = 8'h80;
   localparam logic [31:0] PAD_WORD    = {PAD_BYTE, 24'h00_0000};

endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word
// Combinational shaping of the final message word: keeps the first nbytes
// bytes, drops the rest, and inserts the 0x80 marker right after them.
//   data   in  32  final message word, first byte in [31:24]
//   nbytes in   3  valid bytes, 0..4 (values above 4 behave as 4)
//   word   out 32  masked word with the marker inserted (or data unchanged)
//   spill  out  1  marker does not fit; it belongs at byte 0 of the next word
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [31:0] data,
   input  logic [2:0]  nbytes,
   output logic [31:0] word,
   output logic        spill
);

   always_comb begin
      word  = data;
      spill = 1'b0;
      case (nbytes)
         3'd0:    word = {PAD_BYTE, 24'h00_0000};
         3'd1:    word = {data[31:24], PAD_BYTE, 16'h0000};
         3'd2:    word = {data[31:16], PAD_BYTE, 8'h00};
         3'd3:    word = {data[31:8], PAD_BYTE};
         default: spill = 1'b1;
      endcase
   end

endmodule

// File: rtl/sha256_padder.sv
// sha256_padder
// Streams a big-endian word message in, applies SHA-256 padding and writes
// each 512-bit block to the hash core's register bus (addresses 0..15, then
// the start register at 16), waiting for hash_done between blocks.
//   clk        in   1  system clock
//   reset      in   1  asynchronous reset, active low
//   in_valid   in   1  input word valid
//   in_ready   out  1  word accepted this cycle when in_valid is also high
//   in_data    in  32  message bytes, first byte in [31:24]
//   in_last    in   1  final word of the message
//   in_nbytes  in   3  valid bytes in the final word (0..4, left-justified)
//   chipselect out  1  register-bus select
//   write      out  1  register-bus write strobe
//   address    out  5  0..15 data word, 16 start
//   writedata  out 32  block word or start code
//   hash_done  in   1  core finished hashing the last started block
//   msg_done   out  1  pulse when the final block of a message is hashed
//   busy       out  1  message in progress
//
// state | meaning
// FILL  | accepting message words into the block buffer
// PAD   | decide whether the length fits in this block
// EMIT  | 17 bus writes: words 0..15 then the start code
// WAIT  | waiting for hash_done from the core
// ZERO  | build the extra length-only block
module sha256_padder
   import sha256_pkg::*;
#(
   parameter int LEN_W = 32
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   input  logic [2:0]  in_nbytes,
   output logic        chipselect,
   output logic        write,
   output logic [4:0]  address,
   output logic [31:0] writedata,
   input  logic        hash_done,
   output logic        msg_done,
   output logic        busy
);

   state_e             state_q, state_d;
   logic [31:0]        blk_q [16];
   logic [31:0]        blk_d [16];
   logic [3:0]         wcnt_q, wcnt_d;
   logic [LEN_W-1:0]   bytecnt_q, bytecnt_d;
   logic [4:0]         ptr_q, ptr_d;
   logic               first_q, first_d;
   logic               final_q, final_d;
   logic               pend_q, pend_d;
   logic               carry_q, carry_d;
   logic               in_ready_q, in_ready_d;
   logic               cs_q, cs_d;
   logic [4:0]         address_q, address_d;
   logic [31:0]        writedata_q, writedata_d;
   logic               msg_done_q, msg_done_d;
   logic               busy_q, busy_d;

   logic [31:0]        pad_word;
   logic               pad_spill;
   logic [2:0]         nb_add;
   logic [63:0]        len64;
   logic               take;

   sha256_pad_word u_pad_word (
      .data   (in_data),
      .nbytes (in_nbytes),
      .word   (pad_word),
      .spill  (pad_spill)
   );

   assign take   = in_valid & in_ready_q;
   assign nb_add = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
   assign len64  = 64'(bytecnt_q) << 3;

   always_comb begin
      state_d    = state_q;
      blk_d      = blk_q;
      wcnt_d     = wcnt_q;
      bytecnt_d  = bytecnt_q;
      ptr_d      = ptr_q;
      first_d    = first_q;
      final_d    = final_q;
      pend_d     = pend_q;
      carry_d    = carry_q;
      msg_done_d = 1'b0;
      busy_d     = busy_q;

      case (state_q)
         FILL: begin
            if (take) begin
               busy_d = 1'b1;
               if (!in_last) begin
                  blk_d[wcnt_q] = in_data;
                  wcnt_d        = wcnt_q + 4'd1;
                  bytecnt_d     = bytecnt_q + LEN_W'(4);
                  if (wcnt_q == 4'd15) begin
                     final_d = 1'b0;
                     state_d = EMIT;
                  end
               end else begin
                  blk_d[wcnt_q] = pad_word;
                  bytecnt_d     = bytecnt_q + LEN_W'(nb_add);
                  ptr_d         = {1'b0, wcnt_q} + {4'd0, pad_spill};
                  // A full last word in slot 15 pushes the marker into the
                  // next block; ZERO re-creates it there.
                  if (pad_spill && wcnt_q != 4'd15) begin
                     blk_d[wcnt_q + 4'd1] = PAD_WORD;
                  end
                  state_d = PAD;
               end
            end
         end
         PAD: begin
            if (ptr_q <= 5'd13) begin
               blk_d[14] = len64[63:32];
               blk_d[15] = len64[31:0];
               final_d   = 1'b1;
            end else begin
               final_d = 1'b0;
               pend_d  = 1'b1;
               carry_d = (ptr_q == 5'd16);
            end
            state_d = EMIT;
         end
         EMIT: begin
            if (address_q == ADDR_START) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (hash_done) begin
               for (int i = 0; i < 16; i++) begin
                  blk_d[i] = '0;
               end
               first_d = 1'b0;
               wcnt_d  = '0;
               if (pend_q) begin
                  state_d = ZERO;
               end else begin
                  state_d = FILL;
                  if (final_q) begin
                     msg_done_d = 1'b1;
                     busy_d     = 1'b0;
                     first_d    = 1'b1;
                     bytecnt_d  = '0;
                  end
               end
            end
         end
         ZERO: begin
            blk_d[0]  = carry_q ? PAD_WORD : 32'h0;
            blk_d[14] = len64[63:32];
            blk_d[15] = len64[31:0];
            final_d   = 1'b1;
            pend_d    = 1'b0;
            carry_d   = 1'b0;
            state_d   = EMIT;
         end
         default: state_d = FILL;
      endcase

      // Bus outputs are registered, so they are computed from the next state;
      // the first write of a block therefore reads the buffer's next value.
      in_ready_d  = (state_d == FILL);
      cs_d        = 1'b0;
      address_d   = '0;
      writedata_d = '0;
      if (state_d == EMIT) begin
         cs_d = 1'b1;
         if (state_q != EMIT) begin
            address_d   = 5'd0;
            writedata_d = blk_d[0];
         end else if (address_q == 5'd15) begin
            address_d   = ADDR_START;
            writedata_d = first_q ? START_FIRST : START_CHAIN;
         end else begin
            address_d   = address_q + 5'd1;
            writedata_d = blk_q[address_q[3:0] + 4'd1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= FILL;
         for (int i = 0; i < 16; i++) begin
            blk_q[i] <= '0;
         end
         wcnt_q      <= '0;
         bytecnt_q   <= '0;
         ptr_q       <= '0;
         first_q     <= 1'b1;
         final_q     <= 1'b0;
         pend_q      <= 1'b0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         cs_q        <= 1'b0;
         address_q   <= '0;
         writedata_q <= '0;
         msg_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         wcnt_q      <= wcnt_d;
         bytecnt_q   <= bytecnt_d;
         ptr_q       <= ptr_d;
         first_q     <= first_d;
         final_q     <= final_d;
         pend_q      <= pend_d;
         carry_q     <= carry_d;
         in_ready_q  <= in_ready_d;
         cs_q        <= cs_d;
         address_q   <= address_d;
         writedata_q <= writedata_d;
         msg_done_q  <= msg_done_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign chipselect = cs_q;
   assign write      = cs_q;
   assign address    = address_q;
   assign writedata  = writedata_q;
   assign msg_done   = msg_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder
// Random and directed messages are padded by a byte-level reference model;
// the expected register writes go into a queue that a monitor drains as the
// padder writes. A small core model answers each start write with hash_done
// and optionally throws stray done pulses mid-block.
module tb_sha256_padder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic [2:0]  in_nbytes;
   logic        chipselect;
   logic        write;
   logic [4:0]  address;
   logic [31:0] writedata;
   logic        hash_done;
   logic        msg_done;
   logic        busy;

   always #5 clk = ~clk;

   sha256_padder #(.LEN_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_nbytes  (in_nbytes),
      .chipselect (chipselect),
      .write      (write),
      .address    (address),
      .writedata  (writedata),
      .hash_done  (hash_done),
      .msg_done   (msg_done),
      .busy       (busy)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t  exp_q[$];
   int   n_checks     = 0;
   int   n_errors     = 0;
   int   msg_done_cnt = 0;
   int   msgs_expected = 0;
   bit   stray_en     = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Reference padding: bytes + 0x80 + zeros to 56 mod 64 + 64-bit bit length.
   task automatic model_push(input byte unsigned m[$]);
      byte unsigned    p[$];
      longint unsigned bl;
      int              nblk;
      wr_t             e;
      p = m;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bl = 64'(m.size()) * 64'd8;
      for (int i = 7; i >= 0; i--) p.push_back(8'(bl >> (8 * i)));
      nblk = p.size() / 64;
      for (int b = 0; b < nblk; b++) begin
         for (int j = 0; j < 16; j++) begin
            e.addr = 5'(j);
            e.data = {p[b*64+j*4], p[b*64+j*4+1], p[b*64+j*4+2], p[b*64+j*4+3]};
            exp_q.push_back(e);
         end
         e.addr = 5'd16;
         e.data = (b == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
         exp_q.push_back(e);
      end
   endtask

   // Called at a negedge; returns at the negedge after the transfer.
   task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
      int t;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = last;
      in_nbytes = nb;
      t = 0;
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) timeout_fail("in_ready_wait");
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = $urandom;
      in_nbytes = 3'($urandom_range(0, 7));
   endtask

   // mode 1 with a nonzero multiple-of-4 length: all words non-last, then an
   // empty last word.
   task automatic drive_msg(input byte unsigned m[$], input int mode, input bit zero_fill);
      int          len;
      int          nw;
      int          nb;
      logic [31:0] d;
      byte unsigned v;
      len = m.size();
      if (len == 0) nw = 1;
      else nw = (len + 3) / 4;
      for (int i = 0; i < nw; i++) begin
         d = '0;
         for (int k = 0; k < 4; k++) begin
            if (4 * i + k < len) v = m[4*i+k];
            else v = zero_fill ? 8'h00 : 8'($urandom);
            d = {d[23:0], v};
         end
         if (mode == 1 && len > 0 && len % 4 == 0) begin
            send_word(d, 1'b0, 3'd4);
         end else begin
            nb = (i == nw - 1) ? (len - 4 * i) : 4;
            send_word(d, (i == nw - 1), 3'(nb));
         end
         if (i == 0) chk("busy_after_first_word", busy, 1);
      end
      if (mode == 1 && len > 0 && len % 4 == 0) send_word($urandom, 1'b1, 3'd0);
   endtask

   task automatic send_msg(input int len, input int mode, input bit use_abc);
      byte unsigned m[$];
      int           t;
      m = {};
      if (use_abc) m = {8'h61, 8'h62, 8'h63};
      else for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      model_push(m);
      msgs_expected++;
      drive_msg(m, mode, use_abc);
      t = 0;
      while (msg_done_cnt != msgs_expected && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) timeout_fail("msg_done_wait");
      repeat (3) @(negedge clk);
      chk("msg_done_count", msg_done_cnt, msgs_expected);
      chk("queue_drained", exp_q.size(), 0);
      chk("busy_idle", busy, 0);
   endtask

   task automatic reset_mid_emit();
      byte unsigned m[$];
      int           t;
      m = {8'h61, 8'h62, 8'h63};
      model_push(m);
      drive_msg(m, 0, 1'b1);
      t = 0;
      while (!(chipselect && write && address == 5'd7) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) timeout_fail("emit_addr7_wait");
      #1 reset = 1'b0;
      #1;
      chk("rst_write", write, 0);
      chk("rst_chipselect", chipselect, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_address", address, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Monitor: drains the scoreboard on every bus write.
   initial begin
      wr_t        e;
      bit         prev_wr;
      logic [4:0] prev_addr;
      prev_wr   = 1'b0;
      prev_addr = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset === 1'b1) begin
            if (chipselect && write) begin
               if (exp_q.size() == 0) begin
                  timeout_fail("unexpected_write");
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", address, e.addr);
                  chk("wr_data", writedata, e.data);
               end
               if (address != 5'd0) chk("wr_consecutive", {prev_wr, prev_addr}, {1'b1, address - 5'd1});
            end
            if (msg_done) begin
               msg_done_cnt++;
               chk("done_after_writes", exp_q.size(), 0);
               chk("busy_at_done", busy, 0);
            end
            prev_wr   = chipselect && write;
            prev_addr = address;
         end else begin
            prev_wr = 1'b0;
         end
      end
   end

   // Hash core model.
   initial begin
      int k;
      hash_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset === 1'b1 && chipselect && write && address == 5'd5 && stray_en &&
             $urandom_range(0, 1) == 1) begin
            hash_done = 1'b1;
            @(posedge clk);
            #1 hash_done = 1'b0;
         end else if (reset === 1'b1 && chipselect && write && address == 5'd16) begin
            k = $urandom_range(1, 6);
            repeat (k) begin
               @(posedge clk);
               #1;
               chk("ready_low_in_wait", in_ready, 0);
            end
            hash_done = 1'b1;
            @(posedge clk);
            #1 hash_done = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      in_nbytes = '0;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_chipselect", chipselect, 0);
      chk("reset_write", write, 0);
      chk("reset_address", address, 0);
      chk("reset_writedata", writedata, 0);
      chk("reset_msg_done", msg_done, 0);
      chk("reset_busy", busy, 0);
      reset = 1'b1;
      @(negedge clk);

      send_msg(0, 0, 1'b0);
      send_msg(3, 0, 1'b1);
      send_msg(56, 0, 1'b0);
      send_msg(64, 0, 1'b0);
      send_msg(64, 1, 1'b0);
      stray_en = 1'b1;
      send_msg(55, 0, 1'b0);
      send_msg(57, 0, 1'b0);
      send_msg(60, 1, 1'b0);
      send_msg(119, 0, 1'b0);
      send_msg(120, 0, 1'b0);
      send_msg(128, 1, 1'b0);
      stray_en = 1'b0;

      reset_mid_emit();
      send_msg(3, 0, 1'b1);

      for (int r = 0; r < 8; r++) begin
         stray_en = 1'($urandom_range(0, 1));
         send_msg($urandom_range(0, 150), $urandom_range(0, 1), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Upstream feeder for the SHA-256 accelerator register interface.
- Accepts a message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit-length.
- Emits each 512-bit block as 16 register writes to addresses 0..15, then a start write to address 16, and waits for the hash core's done before sending the next block.

Parameters:
- LEN_W, 32, byte-counter width; message length is limited to 2^LEN_W-1 bytes, and the bit length is zero-extended to 64 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- in_valid  in  1  input word valid
- in_ready  out  1  padder can accept a word this cycle
- in_data  in  32  message bytes; the first byte is in [31:24]
- in_last  in  1  final word of the message
- in_nbytes  in  3  valid bytes in the final word, 0..4, left-justified; ignored when in_last=0
- chipselect  out  1  register-bus select
- write  out  1  register-bus write strobe
- address  out  5  0..15 data word, 16 start
- writedata  out  32  word data, or start code
- hash_done  in  1  single-cycle pulse from the core when a block has been hashed
- msg_done  out  1  one-cycle pulse when the final block's hash_done is received
- busy  out  1  high from the first accepted word until msg_done

Behaviour:
- Reset values: in_ready=1, chipselect=0, write=0, address=0, writedata=0, msg_done=0, busy=0, byte count=0, first-block flag=1, buffer cleared.
- State FILL:
  - in_ready=1; a transfer occurs when in_valid and in_ready are both 1.
  - Each accepted non-last word is stored at buffer[wcnt], wcnt increments, and bytecnt increases by 4.
  - When wcnt reaches 16 on a non-last word, go to EMIT; the message is not yet complete.
  - On in_last, store the word masked to its first in_nbytes bytes, place 0x80 in the next byte position, add in_nbytes to bytecnt, and go to PAD.
  - in_nbytes=0 stores no data; 0x80 lands at byte 0 of word wcnt.
  - in_nbytes=4: 0x80 goes to the next word.
- State PAD (1 cycle): let p = the word index holding 0x80.
  - p<=13: words 14..15 = {32'b0, bytecnt<<3} (64-bit big-endian), then EMIT with final=1.
  - p>=14, or p=16 (0x80 spills past the block): emit the current block with final=0 and set pend_len=1.
  - For p=16, the 0x80 word becomes word 0 of the next block.
- State EMIT (17 cycles): chipselect=write=1 on every cycle.
  - address steps 0..15 with writedata=buffer[address].
  - Then address=16 with writedata = 32'hFFFFFFFF if this is the message's first block (core loads the initial hash value), else 32'hFFFFFFFE (core chains).
  - Then go to WAIT.
  - in_ready=0 throughout EMIT and WAIT.
- State WAIT: chipselect=write=0; hash_done is sampled only in this state, and pulses in other states are ignored.
  - On hash_done: clear the buffer and first-block flag, reset wcnt to 0.
  - Next state: if pend_len, go to ZERO; else if the block was final, pulse msg_done and go to FILL (set first-block flag, bytecnt=0); else go to FILL.
- State ZERO (1 cycle):
  - Buffer is all zero except the carried 0x80 word if p was 16.
  - Words 14..15 = the length; go to EMIT with final=1 and clear pend_len.
- Other rules:
  - bytecnt wraps modulo 2^LEN_W; overflow is unsupported and not flagged.
  - in_valid while in_ready=0 is held off by the source; no data is lost.
  - Reset mid-operation: all outputs return to their reset values immediately (asynchronously), and the partial message is discarded.

Decomposition:
- sha256_pkg holds:
  - the state enum {FILL, PAD, EMIT, WAIT, ZERO};
  - ADDR_START=5'd16;
  - START_FIRST=32'hFFFFFFFF and START_CHAIN=32'hFFFFFFFE;
  - PAD_BYTE=8'h80.
- One combinational sub-module, sha256_pad_word: takes (data, nbytes) and returns the masked word with 0x80 inserted plus a spill flag.

Test Plan:
- Empty message (in_last, in_nbytes=0):
  - one block: word0=0x80000000, words1..15=0;
  - start writedata=0xFFFFFFFF;
  - after hash_done, msg_done pulses once.
- "abc" (in_data=0x61626300, in_nbytes=3, last): word0=0x61626380, words1..14=0, word15=0x00000018; 17 consecutive write cycles.
- 56-byte message (14 words, last word nbytes=4): two blocks.
  - Block 1: word14=0x80000000, word15=0, start=0xFFFFFFFF.
  - Block 2: words0..14=0, word15=0x000001C0, start=0xFFFFFFFE.
- 64-byte message:
  - Block 1: data only, final=0.
  - Block 2: word0=0x80000000, word15=0x00000200.
  - in_ready stays 0 between blocks until hash_done.
- Back-pressure and stray done:
  - hash_done pulsed during EMIT is ignored, and emission continues to address 16;
  - in_valid held high during WAIT consumes nothing.
- Reset: assert reset low at EMIT address 7. write, chipselect and busy drop to 0 immediately; a following "abc" message produces the exact block from the "abc" case.
